// File: rtl/ddr3_cmd_timer_pkg.sv
// Shared DDR3 command codes and timing helpers for the command gate.
// Command codes are the {ras_n,cas_n,we_n} pin encoding.
package ddr3_cmd_timer_pkg;

    typedef enum logic [2:0] {
        CMD_MODE = 3'b000,
        CMD_REFR = 3'b001,
        CMD_PREC = 3'b010,
        CMD_ACTV = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_ZQCL = 3'b110,
        CMD_NOOP = 3'b111
    } cmd_e;

    localparam int BURST_CYC = 4;

    // ceil(ns * MHz / 1000), never below one cycle
    function automatic int ns2cyc(input int ns, input int mhz);
        int c;
        c = (ns * mhz + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// tREFI interval timer with postponed-refresh accounting.
// Overrun is sticky until reset.
module ddr3_refresh_timer
    import ddr3_cmd_timer_pkg::*;
#(
    parameter int TREFI_CYC    = 780,
    parameter int REF_POSTPONE = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic refresh_en_i,
    input  logic ref_acc_i,
    output logic ref_pend_o,
    output logic ref_err_o
);

    localparam int CNT_W  = $clog2(TREFI_CYC + 1);
    localparam int PEND_W = $clog2(REF_POSTPONE + 1);

    localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(TREFI_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_POSTPONE);

    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pending;
    logic              expire;

    assign expire     = refresh_en_i && (cnt == '0);
    assign ref_pend_o = (pending != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (refresh_en_i) begin
            cnt <= expire ? RELOAD : cnt - CNT_W'(1);
        end
    end

    // Simultaneous expiry and REFR accept cancel out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            ref_err_o <= 1'b0;
        end else if (expire && !ref_acc_i) begin
            if (pending == PEND_MAX) begin
                ref_err_o <= 1'b1;
            end else begin
                pending <= pending + PEND_W'(1);
            end
        end else if (ref_acc_i && !expire && pending != '0) begin
            pending <= pending - PEND_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_cmd_timer.sv
// DDR3 inter-command timing gate between the command FSM and the DFI bus.
// Holds off ddl_rdy_o until bank/device timing allows the presented command.
module ddr3_cmd_timer
    import ddr3_cmd_timer_pkg::*;
#(
    parameter int DDR_FREQ_MHZ = 100,
    parameter int DDR_ROW_BITS = 13,
    parameter int TRCD_NS      = 14,
    parameter int TRP_NS       = 14,
    parameter int TRAS_NS      = 35,
    parameter int TWR_NS       = 15,
    parameter int TRTP_NS      = 8,
    parameter int TRFC_NS      = 110,
    parameter int TREFI_NS     = 7800,
    parameter int CWL          = 5,
    parameter int TMOD         = 12,
    parameter int TZQINIT      = 512,
    parameter int REF_POSTPONE = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    refresh_en_i,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic [2:0]              dfi_cmd_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
    output logic                    ref_err_o
);

    localparam int T_RCD  = ns2cyc(TRCD_NS, DDR_FREQ_MHZ);
    localparam int T_RP   = ns2cyc(TRP_NS, DDR_FREQ_MHZ);
    localparam int T_RAS  = ns2cyc(TRAS_NS, DDR_FREQ_MHZ);
    localparam int T_WR   = ns2cyc(TWR_NS, DDR_FREQ_MHZ);
    localparam int T_RTP  = ns2cyc(TRTP_NS, DDR_FREQ_MHZ);
    localparam int T_RFC  = ns2cyc(TRFC_NS, DDR_FREQ_MHZ);
    localparam int T_REFI = ns2cyc(TREFI_NS, DDR_FREQ_MHZ);

    localparam int D_RD   = BURST_CYC;
    localparam int D_WR   = BURST_CYC;
    localparam int D_RDAP = max2(BURST_CYC, T_RTP) + T_RP;
    localparam int D_WRAP = CWL + BURST_CYC + T_WR + T_RP;

    localparam int D_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RFC, TMOD)),
                                max2(max2(D_RDAP, D_WRAP), TZQINIT));

    localparam int DLY_W = $clog2(D_MAX + 1);
    localparam int RAS_W = $clog2(T_RAS + 1);

    localparam logic [RAS_W-1:0] RAS_LOAD = RAS_W'(T_RAS - 1);

    cmd_e             cmd;
    logic [DLY_W-1:0] delay;
    logic [DLY_W-1:0] dly_load;
    logic [RAS_W-1:0] ras;
    logic             ap;
    logic             pclass;
    logic             accept;
    logic             ref_acc;
    logic             unused_seq;

    assign cmd        = cmd_e'(ddl_cmd_i);
    assign ap         = ddl_adr_i[10];
    assign unused_seq = ddl_seq_i;

    // Anything that closes the row must also respect tRAS
    assign pclass = (cmd == CMD_PREC)
                 || (((cmd == CMD_READ) || (cmd == CMD_WRIT)) && ap);

    assign ddl_rdy_o = (delay == '0) && ((ras == '0) || !pclass);
    assign accept    = ddl_req_i && ddl_rdy_o && (cmd != CMD_NOOP);
    assign ref_acc   = accept && (cmd == CMD_REFR);

    always_comb begin
        dly_load = '0;
        unique case (cmd)
            CMD_ACTV: dly_load = DLY_W'(T_RCD - 1);
            CMD_READ: dly_load = ap ? DLY_W'(D_RDAP - 1) : DLY_W'(D_RD - 1);
            CMD_WRIT: dly_load = ap ? DLY_W'(D_WRAP - 1) : DLY_W'(D_WR - 1);
            CMD_PREC: dly_load = DLY_W'(T_RP - 1);
            CMD_REFR: dly_load = DLY_W'(T_RFC - 1);
            CMD_MODE: dly_load = DLY_W'(TMOD - 1);
            CMD_ZQCL: dly_load = DLY_W'(TZQINIT - 1);
            CMD_NOOP: dly_load = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay <= '0;
        end else if (accept) begin
            delay <= dly_load;
        end else if (delay != '0) begin
            delay <= delay - DLY_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ras <= '0;
        end else if (accept && cmd == CMD_ACTV) begin
            ras <= RAS_LOAD;
        end else if (ras != '0) begin
            ras <= ras - RAS_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dfi_cmd_o <= CMD_NOOP;
            dfi_ba_o  <= '0;
            dfi_adr_o <= '0;
        end else begin
            dfi_cmd_o <= accept ? ddl_cmd_i : CMD_NOOP;
            if (accept) begin
                dfi_ba_o  <= ddl_ba_i;
                dfi_adr_o <= ddl_adr_i;
            end
        end
    end

    ddr3_refresh_timer #(
        .TREFI_CYC    (T_REFI),
        .REF_POSTPONE (REF_POSTPONE)
    ) u_refresh (
        .clock        (clock),
        .reset        (reset),
        .refresh_en_i (refresh_en_i),
        .ref_acc_i    (ref_acc),
        .ref_pend_o   (ddl_ref_o),
        .ref_err_o    (ref_err_o)
    );

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// Scenario bench for ddr3_cmd_timer at default 100 MHz timing.
// Accepted commands are queued and matched against the DFI bus.
module tb_ddr3_cmd_timer;

    localparam int RB     = 13;
    localparam int T_RCD  = 2;
    localparam int T_RP   = 2;
    localparam int T_RAS  = 4;
    localparam int T_RFC  = 11;
    localparam int T_REFI = 780;
    localparam int D_RDAP = 4 + T_RP;
    localparam int D_WRAP = 5 + 4 + 2 + T_RP;

    localparam logic [2:0] MODE = 3'b000;
    localparam logic [2:0] REFR = 3'b001;
    localparam logic [2:0] PREC = 3'b010;
    localparam logic [2:0] ACTV = 3'b011;
    localparam logic [2:0] WRIT = 3'b100;
    localparam logic [2:0] READ = 3'b101;
    localparam logic [2:0] ZQCL = 3'b110;
    localparam logic [2:0] NOOP = 3'b111;

    logic          clock;
    logic          reset;
    logic          refresh_en_i;
    logic          ddl_req_i;
    logic          ddl_seq_i;
    logic          ddl_rdy_o;
    logic          ddl_ref_o;
    logic [2:0]    ddl_cmd_i;
    logic [2:0]    ddl_ba_i;
    logic [RB-1:0] ddl_adr_i;
    logic [2:0]    dfi_cmd_o;
    logic [2:0]    dfi_ba_o;
    logic [RB-1:0] dfi_adr_o;
    logic          ref_err_o;

    int errors = 0;
    int checks = 0;
    logic [18:0] sb[$];

    ddr3_cmd_timer dut (
        .clock        (clock),
        .reset        (reset),
        .refresh_en_i (refresh_en_i),
        .ddl_req_i    (ddl_req_i),
        .ddl_seq_i    (ddl_seq_i),
        .ddl_rdy_o    (ddl_rdy_o),
        .ddl_ref_o    (ddl_ref_o),
        .ddl_cmd_i    (ddl_cmd_i),
        .ddl_ba_i     (ddl_ba_i),
        .ddl_adr_i    (ddl_adr_i),
        .dfi_cmd_o    (dfi_cmd_o),
        .dfi_ba_o     (dfi_ba_o),
        .dfi_adr_o    (dfi_adr_o),
        .ref_err_o    (ref_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every non-NOOP DFI cycle must match the oldest accepted command
    always @(negedge clock) begin
        if (reset === 1'b0 && dfi_cmd_o !== NOOP) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dfi_unexpected: got cmd=%b ba=%0d adr=%h expected NOOP",
                         dfi_cmd_o, dfi_ba_o, dfi_adr_o);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                if ({dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== e) begin
                    errors++;
                    $display("FAIL dfi_cmd: got %h expected %h",
                             {dfi_cmd_o, dfi_ba_o, dfi_adr_o}, e);
                end
            end
        end
    end

    task automatic idle();
        ddl_req_i = 1'b0;
        ddl_seq_i = 1'b0;
        ddl_cmd_i = NOOP;
        ddl_ba_i  = '0;
        ddl_adr_i = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        refresh_en_i = 1'b0;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
    endtask

    // Holds a request until accepted; waited = cycles spent before accept
    task automatic present(input logic [2:0] c, input logic [2:0] b,
                           input logic [RB-1:0] a, input int budget,
                           output int waited);
        waited = -1;
        ddl_req_i = 1'b1;
        ddl_cmd_i = c;
        ddl_ba_i  = b;
        ddl_adr_i = a;
        for (int i = 0; i < budget && waited < 0; i++) begin
            @(negedge clock);
            if (ddl_rdy_o === 1'b1) begin
                sb.push_back({c, b, a});
                waited = i;
            end
            @(posedge clock);
            #1;
        end
        idle();
    endtask

    task automatic test_reset();
        apply_reset();
        ddl_cmd_i = PREC;
        ddl_adr_i = 13'h0400;
        #1;
        checks += 6;
        if (dfi_cmd_o !== NOOP) begin
            errors++;
            $display("FAIL rst_cmd: got %b expected %b", dfi_cmd_o, NOOP);
        end
        if (dfi_ba_o !== 3'd0) begin
            errors++;
            $display("FAIL rst_ba: got %0d expected 0", dfi_ba_o);
        end
        if (dfi_adr_o !== '0) begin
            errors++;
            $display("FAIL rst_adr: got %h expected 0", dfi_adr_o);
        end
        if (ddl_ref_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_ref: got %b expected 0", ddl_ref_o);
        end
        if (ref_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_err: got %b expected 0", ref_err_o);
        end
        if (ddl_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdy: got %b expected 1", ddl_rdy_o);
        end
        idle();
    endtask

    task automatic test_act_read();
        int w;
        present(ACTV, 3'd1, 13'h0155, 20, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL ar_act: got wait %0d expected 0", w);
        end
        present(READ, 3'd1, 13'h0010, 20, w);
        checks++;
        if (w !== T_RCD - 1) begin
            errors++;
            $display("FAIL ar_read: got wait %0d expected %0d", w, T_RCD - 1);
        end
        cycles(8);
    endtask

    task automatic test_read_ap();
        int w;
        present(ACTV, 3'd2, 13'h1abc, 20, w);
        cycles(1);
        present(READ, 3'd2, 13'h0420, 20, w);
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL rdap_tras: got wait %0d expected 2", w);
        end
        present(ACTV, 3'd3, 13'h0777, 20, w);
        checks++;
        if (w !== D_RDAP - 1) begin
            errors++;
            $display("FAIL rdap_next: got wait %0d expected %0d", w, D_RDAP - 1);
        end
        cycles(10);
    endtask

    task automatic test_write_ap();
        int w;
        present(ACTV, 3'd4, 13'h0042, 20, w);
        present(WRIT, 3'd4, 13'h0408, 20, w);
        checks++;
        if (w !== T_RAS - 1) begin
            errors++;
            $display("FAIL wrap_tras: got wait %0d expected %0d", w, T_RAS - 1);
        end
        present(PREC, 3'd4, 13'h0000, 30, w);
        checks++;
        if (w !== D_WRAP - 1) begin
            errors++;
            $display("FAIL wrap_next: got wait %0d expected %0d", w, D_WRAP - 1);
        end
        present(ACTV, 3'd5, 13'h0999, 20, w);
        checks++;
        if (w !== T_RP - 1) begin
            errors++;
            $display("FAIL prec_trp: got wait %0d expected %0d", w, T_RP - 1);
        end
        cycles(10);
    endtask

    task automatic test_tras_prec();
        int w;
        present(ACTV, 3'd6, 13'h0321, 20, w);
        present(PREC, 3'd6, 13'h0000, 20, w);
        checks++;
        if (w !== T_RAS - 1) begin
            errors++;
            $display("FAIL prec_tras: got wait %0d expected %0d", w, T_RAS - 1);
        end
        cycles(10);
    endtask

    task automatic test_mode_zq_noop();
        int w;
        ddl_req_i = 1'b1;
        ddl_cmd_i = NOOP;
        ddl_seq_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (ddl_rdy_o !== 1'b1) begin
                errors++;
                $display("FAIL noop_rdy: got %b expected 1", ddl_rdy_o);
            end
        end
        cycles(1);
        idle();
        present(MODE, 3'd0, 13'h0a5a, 20, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL noop_effect: got wait %0d expected 0", w);
        end
        present(ACTV, 3'd7, 13'h0123, 40, w);
        checks++;
        if (w !== 11) begin
            errors++;
            $display("FAIL tmod: got wait %0d expected 11", w);
        end
        present(ZQCL, 3'd0, 13'h0400, 20, w);
        present(ACTV, 3'd1, 13'h0456, 600, w);
        checks++;
        if (w !== 511) begin
            errors++;
            $display("FAIL tzqinit: got wait %0d expected 511", w);
        end
        cycles(10);
    endtask

    task automatic test_refresh();
        int w;
        int n;
        apply_reset();
        refresh_en_i = 1'b1;
        n = -1;
        for (int i = 0; i < T_REFI + 50 && n < 0; i++) begin
            @(negedge clock);
            if (ddl_ref_o === 1'b1) n = i;
            @(posedge clock);
            #1;
        end
        checks++;
        if (n !== T_REFI) begin
            errors++;
            $display("FAIL ref_rise: got cycle %0d expected %0d", n, T_REFI);
        end
        present(REFR, 3'd0, 13'h0000, 5, w);
        checks += 2;
        if (ddl_ref_o !== 1'b0) begin
            errors++;
            $display("FAIL ref_clear: got %b expected 0", ddl_ref_o);
        end
        if (w !== 0) begin
            errors++;
            $display("FAIL ref_acc: got wait %0d expected 0", w);
        end
        present(ACTV, 3'd2, 13'h0111, 30, w);
        checks++;
        if (w !== T_RFC - 1) begin
            errors++;
            $display("FAIL trfc: got wait %0d expected %0d", w, T_RFC - 1);
        end
        refresh_en_i = 1'b0;
        cycles(10);
    endtask

    task automatic test_overrun();
        int n;
        apply_reset();
        refresh_en_i = 1'b1;
        n = -1;
        for (int i = 0; i < 9 * T_REFI + 80 && n < 0; i++) begin
            @(negedge clock);
            if (ref_err_o === 1'b1) n = i;
            @(posedge clock);
            #1;
        end
        checks += 2;
        if (n !== 9 * T_REFI) begin
            errors++;
            $display("FAIL err_rise: got cycle %0d expected %0d", n, 9 * T_REFI);
        end
        if (ddl_ref_o !== 1'b1) begin
            errors++;
            $display("FAIL err_pend: got %b expected 1", ddl_ref_o);
        end
        cycles(T_REFI + 20);
        refresh_en_i = 1'b0;
        checks++;
        if (ref_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", ref_err_o);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        present(REFR, 3'd0, 13'h0000, 5, w);
        @(negedge clock);
        cycles(1);
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (ddl_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_rdy: got %b expected 1", ddl_rdy_o);
        end
        if (dfi_cmd_o !== NOOP) begin
            errors++;
            $display("FAIL mid_cmd: got %b expected %b", dfi_cmd_o, NOOP);
        end
        if (ddl_ref_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_ref: got %b expected 0", ddl_ref_o);
        end
        if (ref_err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_err: got %b expected 0", ref_err_o);
        end
        cycles(2);
        reset = 1'b0;
        present(ACTV, 3'd3, 13'h0bcd, 5, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL mid_after: got wait %0d expected 0", w);
        end
        cycles(5);
    endtask

    initial begin
        reset = 1'b1;
        refresh_en_i = 1'b0;
        idle();
        test_reset();
        test_act_read();
        test_read_ap();
        test_write_ap();
        test_tras_prec();
        test_mode_zq_noop();
        test_refresh();
        test_overrun();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_timer.md
Name: ddr3_cmd_timer

Overview:
Data-layer command gate directly downstream of the DDR3 command FSM. It accepts one command at a time over the ddl_* request/ready handshake, enforces DDR3 inter-command timing (tRCD, tRAS, tRP, tWR, tRFC, tMOD, tZQinit, tCCD), and forwards each accepted command for one cycle onto the DFI command bus. It also schedules periodic refresh, requests it via ddl_ref_o, tracks postponed refreshes, and flags refresh overrun.

Parameters:
DDR_FREQ_MHZ, 100, controller clock frequency; converts ns to cycles as ceil(ns*MHz/1000), minimum 1
DDR_ROW_BITS, 13, row/address bus width
TRCD_NS, 14, ACT to RD/WR
TRP_NS, 14, PRE to next command
TRAS_NS, 35, ACT to precharge (explicit or auto)
TWR_NS, 15, write recovery
TRTP_NS, 8, read to precharge
TRFC_NS, 110, REF to next command
TREFI_NS, 7800, refresh interval
CWL, 5, write latency in cycles
TMOD, 12, MRS to next command, in cycles
TZQINIT, 512, ZQCL to next command, in cycles
REF_POSTPONE, 8, maximum number of outstanding refreshes

Ports:
clock  in  1  controller clock
reset  in  1  asynchronous reset, active-high
refresh_en_i  in  1  enables the tREFI timer; held low during initialisation
ddl_req_i  in  1  command valid
ddl_seq_i  in  1  burst continues; informational only, no timing effect
ddl_rdy_o  out  1  command may be accepted this cycle
ddl_ref_o  out  1  one or more refreshes pending
ddl_cmd_i  in  3  command code
ddl_ba_i  in  3  bank address
ddl_adr_i  in  DDR_ROW_BITS  row/column address; bit 10 = auto-precharge / all-banks
dfi_cmd_o  out  3  registered DFI command; NOOP when idle
dfi_ba_o  out  3  registered bank address
dfi_adr_o  out  DDR_ROW_BITS  registered address
ref_err_o  out  1  sticky refresh overrun

Behaviour:
- Command encoding {ras_n,cas_n,we_n}: MODE=000, REFR=001, PREC=010, ACTV=011, WRIT=100, READ=101, ZQCL=110, NOOP=111.
- Reset values: dfi_cmd_o=NOOP, dfi_ba_o=0, dfi_adr_o=0, ddl_ref_o=0, ref_err_o=0, delay counter=0, tRAS counter=0, pending=0, tREFI counter=TREFI cycles-1. Reset asserted mid-operation clears all state immediately, including any in-flight delay.
- ddl_rdy_o is combinational from the registered counters, ddl_cmd_i and ddl_adr_i[10]. It never depends on ddl_req_i.
- ddl_rdy_o = (delay==0) && (ras==0 || !pclass), where pclass = PREC, or READ/WRIT with adr[10]=1.
- Accept occurs when ddl_req_i && ddl_rdy_o && cmd!=NOOP. A NOOP request is ignored and has no timing effect.
- Accept at cycle t: dfi_* carries the command at t+1 only, NOOP otherwise. Delay is loaded with D-1, so the next accept can occur no earlier than t+D.
- D per command:
  - ACTV: tRCD
  - READ: 4
  - READ with AP: max(4,tRTP)+tRP
  - WRIT: 4
  - WRIT with AP: CWL+4+tWR+tRP
  - PREC: tRP
  - REFR: tRFC
  - MODE: TMOD
  - ZQCL: TZQINIT
- ACTV accept loads the tRAS counter with tRAS-1; it decrements to 0 and holds there.
- Refresh timer:
  - Counts down while refresh_en_i=1; holds while refresh_en_i=0.
  - At 0 it reloads TREFI-1 and increments pending.
  - A REFR accept decrements pending.
  - If expiry and REFR accept occur in the same cycle, pending is unchanged.
  - ddl_ref_o = (pending!=0).
  - Expiry with pending==REF_POSTPONE saturates pending and sets ref_err_o, which clears only on reset.
- Default cycle counts at 100 MHz: tRCD=2, tRP=2, tRAS=4, tWR=2, tRTP=1, tRFC=11, tREFI=780.

Decomposition:
- CMD_* codes come from the shared ddr3_settings include.
- ns-to-cycle conversion goes in the same include as a constant function.
- One natural sub-module: ddr3_refresh_timer (tREFI counter, pending count, ref_err).

Test Plan:
- ACTV accepted at cycle 0 -> dfi_cmd_o=011 at cycle 1; ddl_rdy_o low at cycle 1, high at cycle 2; READ accepted at cycle 2 -> dfi_cmd_o=101 at cycle 3.
- ACTV at 0, READ with adr[10]=1 presented from cycle 2 -> rdy low until cycle 4 (tRAS); accept at cycle 4; next accept no earlier than cycle 10 (D=6).
- ACTV at 0, WRIT with adr[10]=1 accepted at cycle 4 -> next accept no earlier than cycle 17 (D=13).
- refresh_en_i=1 from cycle 0 -> ddl_ref_o rises at cycle 780; REFR accepted -> ddl_ref_o low the next cycle, rdy low for 11 cycles.
- Nine tREFI expiries with no REFR -> pending=8 and ref_err_o=1 on the ninth expiry; ref_err_o stays high until reset.
- Reset asserted mid-tRFC -> ddl_rdy_o high, dfi_cmd_o=NOOP, ddl_ref_o=0 immediately.
